memory_access_arbiter: RTL and testbench
========================================

# memory_access_arbiter

Two-port arbiter and sequencer for the shared 32-bit data / 16-bit address memory register. It sits between the CPU's instruction-fetch unit (port 0) and the load/store unit (port 1) and lets both use the single storage element without conflict. It grants one requester at a time with round-robin fairness, drives the memory-side address, data and enable for a fixed access latency, and returns read data or a write acknowledge to the owner.

## Interface
- BITS_DATA, 32, data width
- BITS_ADDR, 16, address width
- MEM_LATENCY, 1, cycles memEn is held before memRdata is valid; legal range 1..15

- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  access request, bit i = port i; held until gnt[i]
- we  in  2  per-port write enable (1 = write, 0 = read); sampled with req
- addr0, addr1  in  BITS_ADDR  per-port address
- wdata0, wdata1  in  BITS_DATA  per-port write data
- gnt  out  2  one-cycle grant pulse, one-hot or zero
- done  out  2  one-cycle completion pulse to owner
- rdata  out  BITS_DATA  read result, valid when done is high for a read
- memEn  out  1  memory access active
- memWe  out  1  memory write strobe
- memAddr  out  BITS_ADDR  memory address
- memWdata  out  BITS_DATA  memory write data
- memRdata  in  BITS_DATA  memory read data

## Operation
- FSM states: IDLE, BUSY, RESP. Encoding is 2-bit binary: IDLE=0, BUSY=1, RESP=2. The value 3 is illegal and recovers to IDLE on the next clock.
- IDLE:
  - if req != 0 at a rising edge: select owner, latch we/addr/wdata of owner, pulse gnt[owner], go BUSY, load counter = MEM_LATENCY-1
  - else stay IDLE
- Selection:
  - single request wins
  - if req == 2'b11, grant the port that is not lastOwner
  - lastOwner resets to 1, so port 0 wins the first contention
  - lastOwner updates on every grant
- BUSY:
  - memEn=1; memWe=latched we; memAddr/memWdata = latched values (stable for the whole state)
  - counter decrements each cycle; when counter==0: if read, capture memRdata into rdata; go RESP
- RESP:
  - done[owner]=1 for exactly one cycle; memEn=0, memWe=0; go IDLE
  - rdata holds its value until the next read completes; writes do not modify rdata
- Requester rules:
  - deassert req in the cycle after gnt; a req still high in IDLE is a new request
  - addr/we/wdata are don't-care after gnt

## Timing
- Reset (async assert, sync release by system): state=IDLE, gnt=0, done=0, rdata=0, memEn=0, memWe=0, memAddr=0, memWdata=0, lastOwner=1, counter=0.
- All outputs are registered; nothing is combinational from req to gnt.
- Request seen at edge N:
  - gnt high during cycle N..N+1
  - memEn high for MEM_LATENCY cycles starting at edge N
  - done high one cycle after memEn falls
- Total latency req-sampled to done = MEM_LATENCY+1 edges. Back-to-back throughput = one access per MEM_LATENCY+2 cycles.
- Requests arriving while BUSY/RESP are ignored (not queued) until IDLE samples them.
- Reset asserted mid-access: immediate abort, all outputs to reset values, no done pulse; the in-flight write may or may not have reached memory.

## Structure
- Shared package/header `arb_defs`: state encodings (ARB_IDLE, ARB_BUSY, ARB_RESP), port index constants PORT_FETCH=0, PORT_LSU=1.
- One sub-module is natural: `rr_select2`, a combinational 2-way round-robin picker (req, lastOwner -> owner, valid).
- Everything else lives in memory_access_arbiter: FSM, latency counter, latch registers.

## Test plan
- Reset: hold rst_n=0 with req=2'b11 -> gnt=0, done=0, memEn=0, rdata=0; after release, the first grant is port 0.
- Single write then read, MEM_LATENCY=1:
  - port 1 writes addr 0x0010, data 0xDEADBEEF -> gnt=2'b10 after 1 edge; memWe=1, memAddr=0x0010 for 1 cycle; done=2'b10
  - port 0 read of 0x0010 with memRdata=0xDEADBEEF -> done=2'b01, rdata=0xDEADBEEF
- Contention: req=2'b11 held continuously -> grants alternate 01,10,01,10; each done matches its grant; no port is served twice in a row.
- Latency: MEM_LATENCY=4, port 0 read -> memEn high exactly 4 cycles; done 5 edges after req sampled; memAddr stable throughout.
- Ignored request: port 1 raises req while BUSY -> no gnt until RESP→IDLE, then gnt=2'b10 on the next edge.
- Reset mid-access: assert rst_n=0 during the 2nd BUSY cycle (MEM_LATENCY=4) -> memEn=0 immediately, no done; the next request after release is serviced normally.

Source files
------------

// File: rtl/memory_access_arbiter_pkg.sv
// Shared definitions for the two-port memory access arbiter.
//   arb_state_e : sequencer states (2-bit binary, value 3 unused)
//   PORT_FETCH  : instruction-fetch requester index
//   PORT_LSU    : load/store requester index
//   CNT_W       : latency counter width (covers MEM_LATENCY 1..15)
package arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/memory_access_arbiter_rr_select2.sv
// Combinational 2-way round-robin picker.
//   req        in  2  request vector, bit i = port i
//   last_owner in  1  port granted most recently
//   owner      out 1  selected port (meaningful when valid)
//   valid      out 1  at least one request present
module rr_select2
  import arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    owner = PORT_FETCH;
    case (req)
      2'b01:   owner = PORT_FETCH;
      2'b10:   owner = PORT_LSU;
      // On contention the port that did not win last time is served.
      2'b11:   owner = ~last_owner;
      default: owner = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/memory_access_arbiter.sv
// Two-port arbiter/sequencer for the shared memory register.
//   clk, rst_n            clock, asynchronous active-low reset
//   req[1:0], we[1:0]     per-port request / write enable
//   addr0/1, wdata0/1     per-port address and write data
//   gnt[1:0]              one-cycle grant pulse
//   done[1:0]             one-cycle completion pulse to the owner
//   rdata                 last completed read result
//   memEn/memWe/memAddr/memWdata  memory-side access, registered
//   memRdata              memory read data, sampled on the last BUSY cycle
module memory_access_arbiter
  import arb_defs::*;
#(
  parameter int unsigned BITS_DATA   = 32,
  parameter int unsigned BITS_ADDR   = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_DATA-1:0] wdata0,
  input  logic [BITS_DATA-1:0] wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [BITS_DATA-1:0] rdata,
  output logic                 memEn,
  output logic                 memWe,
  output logic [BITS_ADDR-1:0] memAddr,
  output logic [BITS_DATA-1:0] memWdata,
  input  logic [BITS_DATA-1:0] memRdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_owner_q, last_owner_d;
  logic                 owner_q, owner_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [BITS_DATA-1:0] rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [BITS_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [BITS_DATA-1:0] mem_wdata_q, mem_wdata_d;

  logic sel_owner;
  logic sel_valid;

  rr_select2 u_rr_select2 (
    .req        (req),
    .last_owner (last_owner_q),
    .owner      (sel_owner),
    .valid      (sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      last_owner_q <= PORT_LSU;
      owner_q      <= PORT_FETCH;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    gnt_d        = '0;
    done_d       = '0;
    rdata_d      = rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ARB_IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (sel_valid) begin
          owner_d           = sel_owner;
          last_owner_d      = sel_owner;
          gnt_d[PORT_FETCH] = (sel_owner == PORT_FETCH);
          gnt_d[PORT_LSU]   = (sel_owner == PORT_LSU);
          // Memory-side signals are launched on the grant edge so memEn
          // covers exactly MEM_LATENCY cycles.
          mem_en_d          = 1'b1;
          mem_we_d          = we[sel_owner];
          mem_addr_d        = (sel_owner == PORT_LSU) ? addr1 : addr0;
          mem_wdata_d       = (sel_owner == PORT_LSU) ? wdata1 : wdata0;
          cnt_d             = CNT_LOAD;
          state_d           = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        if (cnt_q == '0) begin
          if (!mem_we_q) begin
            rdata_d = memRdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ARB_RESP: begin
        done_d[PORT_FETCH] = (owner_q == PORT_FETCH);
        done_d[PORT_LSU]   = (owner_q == PORT_LSU);
        mem_en_d           = 1'b0;
        mem_we_d           = 1'b0;
        state_d            = ARB_IDLE;
      end

      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = ARB_IDLE;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign memEn    = mem_en_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Bench for memory_access_arbiter: one instance with MEM_LATENCY=1 (index 0)
// and one with MEM_LATENCY=4 (index 1), each backed by a small memory.
module tb_memory_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req      [2];
  logic [1:0]  we       [2];
  logic [15:0] addr0    [2];
  logic [15:0] addr1    [2];
  logic [31:0] wdata0   [2];
  logic [31:0] wdata1   [2];
  logic [1:0]  gnt      [2];
  logic [1:0]  done     [2];
  logic [31:0] rdata    [2];
  logic        memEn    [2];
  logic        memWe    [2];
  logic [15:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];

  memory_access_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt(gnt[0]), .done(done[0]), .rdata(rdata[0]),
    .memEn(memEn[0]), .memWe(memWe[0]), .memAddr(memAddr[0]),
    .memWdata(memWdata[0]), .memRdata(memRdata[0])
  );

  memory_access_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt(gnt[1]), .done(done[1]), .rdata(rdata[1]),
    .memEn(memEn[1]), .memWe(memWe[1]), .memAddr(memAddr[1]),
    .memWdata(memWdata[1]), .memRdata(memRdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memories driven only by the DUT memory-side outputs.
  logic [31:0] mem [2][256];
  logic        mem_init;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_val(a);
      end else if (memEn[k] && memWe[k]) begin
        mem[k][memAddr[k][7:0]] <= memWdata[k];
      end
    end
  end

  assign memRdata[0] = mem[0][memAddr[0][7:0]];
  assign memRdata[1] = mem[1][memAddr[1][7:0]];

  // Transaction-level reference state.
  logic [31:0] model_mem   [2][256];
  int          model_last  [2];
  logic [31:0] model_rdata [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s: observed %h expected %h", k, tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 2; k++) begin
      model_last[k]  = 1;
      model_rdata[k] = 32'h0;
    end
  endtask

  task automatic rand_payload(input int k);
    we[k]     = 2'($urandom_range(0, 3));
    addr0[k]  = 16'($urandom_range(0, 15));
    addr1[k]  = 16'($urandom_range(0, 15));
    wdata0[k] = $urandom;
    wdata1[k] = $urandom;
  endtask

  task automatic check_reset_outputs(input int k);
    check(k, "rst_gnt",      32'(gnt[k]),   32'h0);
    check(k, "rst_done",     32'(done[k]),  32'h0);
    check(k, "rst_memEn",    32'(memEn[k]), 32'h0);
    check(k, "rst_memWe",    32'(memWe[k]), 32'h0);
    check(k, "rst_rdata",    rdata[k],      32'h0);
    check(k, "rst_memAddr",  32'(memAddr[k]), 32'h0);
    check(k, "rst_memWdata", memWdata[k],   32'h0);
  endtask

  // Starts at a negedge with the DUT idle; adds add_req to the pending
  // requests, expects a grant on the next edge, follows the access through
  // and returns at the negedge where done is high.
  task automatic run_txn(input int k, input logic [1:0] add_req, input logic [1:0] busy_req);
    logic [1:0]  r;
    logic [1:0]  exp_oh;
    int          own;
    int          lat;
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    lat = (k == 0) ? 1 : 4;
    r = req[k] | add_req;
    req[k] = r;
    if (r == 2'b11) own = 1 - model_last[k];
    else            own = r[1] ? 1 : 0;
    exp_oh = (own == 1) ? 2'b10 : 2'b01;
    w = we[k][own];
    a = (own == 1) ? addr1[k] : addr0[k];
    d = (own == 1) ? wdata1[k] : wdata0[k];

    @(negedge clk);
    check(k, "gnt", 32'(gnt[k]), 32'(exp_oh));
    check(k, "done_at_gnt", 32'(done[k]), 32'h0);
    model_last[k] = own;
    req[k][own] = 1'b0;
    req[k] = req[k] | busy_req;
    rand_payload(k);

    for (int c = 0; c < lat; c++) begin
      if (c != 0) begin
        @(negedge clk);
        check(k, "gnt_busy", 32'(gnt[k]), 32'h0);
      end
      check(k, "memEn_busy", 32'(memEn[k]), 32'h1);
      check(k, "memWe_busy", 32'(memWe[k]), 32'(w));
      check(k, "memAddr_busy", 32'(memAddr[k]), 32'(a));
      if (w) check(k, "memWdata_busy", memWdata[k], d);
      check(k, "done_busy", 32'(done[k]), 32'h0);
    end

    @(negedge clk);
    check(k, "memEn_resp", 32'(memEn[k]), 32'h0);
    check(k, "memWe_resp", 32'(memWe[k]), 32'h0);
    check(k, "done_resp", 32'(done[k]), 32'h0);
    check(k, "gnt_resp", 32'(gnt[k]), 32'h0);
    if (w) model_mem[k][a[7:0]] = d;
    else   model_rdata[k] = model_mem[k][a[7:0]];

    @(negedge clk);
    check(k, "done", 32'(done[k]), 32'(exp_oh));
    check(k, "rdata", rdata[k], model_rdata[k]);
    check(k, "memEn_done", 32'(memEn[k]), 32'h0);
    check(k, "gnt_done", 32'(gnt[k]), 32'h0);
  endtask

  task automatic drain(input int k);
    for (int g = 0; g < 4; g++) begin
      if (req[k] != 2'b00) run_txn(k, 2'b00, 2'b00);
    end
  endtask

  task automatic random_phase(input int k, input int n);
    logic [1:0] add;
    logic [1:0] busy;
    for (int i = 0; i < n; i++) begin
      rand_payload(k);
      add  = 2'($urandom_range(0, 3));
      busy = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ((req[k] | add) == 2'b00) begin
        @(negedge clk);
        check(k, "idle_gnt", 32'(gnt[k]), 32'h0);
        check(k, "idle_done", 32'(done[k]), 32'h0);
        check(k, "idle_memEn", 32'(memEn[k]), 32'h0);
      end else begin
        run_txn(k, add, busy);
      end
    end
    drain(k);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 2'b11;
      we[k] = 2'b00;
      addr0[k] = '0;
      addr1[k] = '0;
      wdata0[k] = '0;
      wdata1[k] = '0;
      for (int a = 0; a < 256; a++) model_mem[k][a] = init_val(a);
    end
    reset_models();

    // Reset held with both requests high.
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    mem_init = 1'b0;
    req[1] = 2'b00;
    rst_n = 1'b1;

    // First contention after reset goes to port 0, then grants alternate.
    rand_payload(0);
    run_txn(0, 2'b11, 2'b00);
    for (int i = 0; i < 4; i++) begin
      rand_payload(0);
      run_txn(0, 2'b11, 2'b00);
    end
    drain(0);

    // Port 1 write followed by port 0 read of the same location.
    we[0] = 2'b10;
    addr1[0] = 16'h0010;
    wdata1[0] = 32'hDEAD_BEEF;
    run_txn(0, 2'b10, 2'b00);
    we[0] = 2'b00;
    addr0[0] = 16'h0010;
    run_txn(0, 2'b01, 2'b00);
    check(0, "rdata_deadbeef", rdata[0], 32'hDEAD_BEEF);

    random_phase(0, 30);

    // Four-cycle latency read, then a request raised while busy.
    we[1] = 2'b00;
    addr0[1] = 16'h0005;
    run_txn(1, 2'b01, 2'b00);
    rand_payload(1);
    run_txn(1, 2'b01, 2'b10);
    rand_payload(1);
    run_txn(1, 2'b00, 2'b00);

    random_phase(1, 20);

    // Reset asserted in the second BUSY cycle of a read.
    we[1] = 2'b00;
    addr0[1] = 16'h0003;
    req[1] = 2'b01;
    @(negedge clk);
    check(1, "mid_gnt", 32'(gnt[1]), 32'h1);
    req[1] = 2'b00;
    @(negedge clk);
    check(1, "mid_memEn_before", 32'(memEn[1]), 32'h1);
    #1 rst_n = 1'b0;
    reset_models();
    #1;
    check_reset_outputs(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(1, "mid_no_done", 32'(done[1]), 32'h0);
      check(1, "mid_memEn_held", 32'(memEn[1]), 32'h0);
    end
    rst_n = 1'b1;
    rand_payload(1);
    run_txn(1, 2'b11, 2'b00);
    rand_payload(1);
    run_txn(1, 2'b00, 2'b00);
    random_phase(1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
